// File: rtl/neuron_mac_scheduler_pkg.sv
// Shared definitions for the neuron MAC scheduler, its layer controller and activation stage.
package neuron_mac_scheduler_pkg;

   localparam int N_IN_DEF  = 8;
   localparam int N_OUT_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/neuron_mac_scheduler_if.sv
// Start/bias, memory-read and result-handshake signals of the neuron MAC scheduler.
interface neuron_mac_scheduler_if
   import neuron_mac_scheduler_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int ADDR_W = 4
);
   logic              start;
   logic [N_OUT-1:0]  bias;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [N_IN-1:0]   x_data;
   logic [N_IN-1:0]   w_data;
   logic              busy;
   logic [N_OUT-1:0]  acc_out;
   logic              out_valid;
   logic              out_ready;

   // master is the scheduler; slave is the surrounding controller, memories and consumer
   modport master (
      input  start, bias, x_data, w_data, out_ready,
      output mem_addr, mem_rd_en, busy, acc_out, out_valid
   );

   modport slave (
      output start, bias, x_data, w_data, out_ready,
      input  mem_addr, mem_rd_en, busy, acc_out, out_valid
   );

endinterface

// File: rtl/neuron_mac_scheduler_si_upscaler.sv
// Sign-extends a two's complement word from N_IN to N_OUT bits.
module si_upscaler #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 32
) (
   input  logic [N_IN-1:0]  din,
   output logic [N_OUT-1:0] dout
);

   assign dout = {{(N_OUT - N_IN){din[N_IN-1]}}, din};

endmodule

// File: rtl/neuron_mac_scheduler.sv
// Walks the input/weight memories for one neuron and accumulates bias + sum(x*w), wrapping mod 2**N_OUT.
module neuron_mac_scheduler
   import neuron_mac_scheduler_pkg::*;
#(
   parameter int N_IN     = N_IN_DEF,
   parameter int N_OUT    = N_OUT_DEF,
   parameter int N_INPUTS = 16,
   parameter int ADDR_W   = 4
) (
   input logic                   clk,
   input logic                   rst,
   neuron_mac_scheduler_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] issue_cnt;
   logic              rd_vld;
   logic [N_OUT-1:0]  acc;
   logic [N_OUT-1:0]  x_ext, w_ext, prod, acc_sum;

   si_upscaler #(.N_IN(N_IN), .N_OUT(N_OUT)) u_x_ext (.din(bus.x_data), .dout(x_ext));
   si_upscaler #(.N_IN(N_IN), .N_OUT(N_OUT)) u_w_ext (.din(bus.w_data), .dout(w_ext));

   // low N_OUT bits of the product are the same for signed and unsigned once both are extended
   assign prod    = x_ext * w_ext;
   assign acc_sum = acc + prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (issue_cnt == LAST) state_nxt = DRAIN;
         DRAIN:   state_nxt = HOLD;
         HOLD:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt     <= '0;
         rd_vld        <= 1'b0;
         acc           <= '0;
         bus.mem_addr  <= '0;
         bus.mem_rd_en <= 1'b0;
         bus.busy      <= 1'b0;
         bus.acc_out   <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         rd_vld <= bus.mem_rd_en;
         if (rd_vld) acc <= acc_sum;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc           <= bus.bias;
                  issue_cnt     <= '0;
                  bus.mem_addr  <= '0;
                  bus.mem_rd_en <= 1'b1;
                  bus.busy      <= 1'b1;
               end
            end
            RUN: begin
               if (issue_cnt == LAST) begin
                  bus.mem_rd_en <= 1'b0;
               end else begin
                  issue_cnt    <= issue_cnt + 1'b1;
                  bus.mem_addr <= bus.mem_addr + 1'b1;
               end
            end
            // the last product lands on this edge, so publish the summed value directly
            DRAIN: begin
               bus.acc_out   <= acc_sum;
               bus.out_valid <= 1'b1;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
